// File: rtl/svpwm_pkg.sv
// Shared types for the SVPWM front end.
// Sample/result types, Clarke bundles and the scheduler state enum.
package svpwm_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t a;
    sample_t b;
    sample_t c;
  } abc_t;

  typedef struct packed {
    sample_t alpha;
    sample_t beta;
    sample_t gamma;
  } ab0_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// First request at or above ptr, wrapping, wins.
module rr_arbiter #(
  parameter int NCH = 4,
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx,
  output logic           any
);

  logic [IW-1:0] j;

  // Walk from farthest to nearest so the nearest hit is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % NCH);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clarke_rr_scheduler.sv
// Round-robin scheduler sharing one Clarke unit among NCH samplers.
// Holds operands for the unit's latency, then returns a tagged result.
module clarke_rr_scheduler
  import svpwm_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int W        = 16,
  parameter int XF_LAT   = 1,
  parameter int IMBAL_TH = 512,
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NCH-1:0]             req_valid,
  output logic [NCH-1:0]             req_ready,
  input  logic [NCH-1:0][W-1:0]      req_a,
  input  logic [NCH-1:0][W-1:0]      req_b,
  input  logic [NCH-1:0][W-1:0]      req_c,
  output logic signed [W-1:0]        xf_a,
  output logic signed [W-1:0]        xf_b,
  output logic signed [W-1:0]        xf_c,
  input  logic signed [W-1:0]        xf_alpha,
  input  logic signed [W-1:0]        xf_beta,
  input  logic signed [W-1:0]        xf_gamma,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [IW-1:0]              res_ch,
  output logic signed [W-1:0]        res_alpha,
  output logic signed [W-1:0]        res_beta,
  output logic signed [W-1:0]        res_gamma,
  output logic                       res_imbal,
  output logic                       busy
);

  localparam int CW = 4;

  sched_state_e  state_q;
  sched_state_e  state_d;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_nxt;
  logic [CW-1:0] cnt_q;
  logic [NCH-1:0] gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  logic          accept;
  logic          last;

  logic signed [W:0] g_ext;
  logic [W:0]        g_mag;
  logic              imbal_d;

  rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign accept  = (state_q == IDLE) && gnt_any;
  assign last    = (state_q == WAIT) && (cnt_q == CW'(1));
  assign ptr_nxt = (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;

  // One extra bit so the most negative gamma has a representable magnitude.
  assign g_ext   = {xf_gamma[W-1], xf_gamma};
  assign g_mag   = g_ext[W] ? -g_ext : g_ext;
  assign imbal_d = g_mag > (W+1)'(IMBAL_TH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)    state_d = WAIT;
      WAIT: if (last)      state_d = DONE;
      DONE: if (res_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = 1'b1;
    if (state_q == IDLE) begin
      req_ready = gnt;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      cnt_q     <= '0;
      xf_a      <= '0;
      xf_b      <= '0;
      xf_c      <= '0;
      res_ch    <= '0;
      res_alpha <= '0;
      res_beta  <= '0;
      res_gamma <= '0;
      res_imbal <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      if (accept) begin
        xf_a   <= req_a[gnt_idx];
        xf_b   <= req_b[gnt_idx];
        xf_c   <= req_c[gnt_idx];
        res_ch <= gnt_idx;
        ptr_q  <= ptr_nxt;
        cnt_q  <= CW'(XF_LAT);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (last) begin
        res_alpha <= xf_alpha;
        res_beta  <= xf_beta;
        res_gamma <= xf_gamma;
        res_imbal <= imbal_d;
        res_valid <= 1'b1;
      end else if ((state_q == DONE) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
